// File: rtl/dbb_r_fifo.sv
// ============================================================================
// Module   : dbb_r_fifo
// Brief    : Elastic buffer on the NVDLA DBB AXI R channel with burst counting
//            and mid-burst ID checking. Define DBB_R_FIFO_BYPASS_EN to enable
//            zero-latency pass-through when the buffer is empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dbb_r_fifo #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_r_valid,
    output logic                       s_r_ready,
    input  logic [DATA_WIDTH-1:0]      s_r_data,
    input  logic [ID_WIDTH-1:0]        s_r_id,
    input  logic                       s_r_last,
    output logic                       m_r_valid,
    input  logic                       m_r_ready,
    output logic [DATA_WIDTH-1:0]      m_r_data,
    output logic [ID_WIDTH-1:0]        m_r_id,
    output logic                       m_r_last,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [15:0]                bursts_o,
    output logic                       err_o
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } burst_state_t;

    logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
    logic [ID_WIDTH-1:0]   r_mem_id   [DEPTH];
    logic                  r_mem_last [DEPTH];

    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;
    logic [15:0]           r_bursts;
    logic                  r_err;
    logic [ID_WIDTH-1:0]   r_burst_id;
    burst_state_t          r_state;
    burst_state_t          w_state_next;

    logic                  w_push;
    logic                  w_store;
    logic                  w_deq;
    logic                  w_pop;
    logic                  w_capture;
    logic                  w_id_mismatch;

    assign s_r_ready = (r_count != c_full);
    assign w_push    = s_r_valid & s_r_ready;

`ifdef DBB_R_FIFO_BYPASS_EN
    logic w_empty;
    assign w_empty   = (r_count == '0);
    assign m_r_valid = w_empty ? s_r_valid : 1'b1;
    assign m_r_data  = w_empty ? s_r_data  : r_mem_data[r_rd_ptr];
    assign m_r_id    = w_empty ? s_r_id    : r_mem_id[r_rd_ptr];
    assign m_r_last  = w_empty ? s_r_last  : r_mem_last[r_rd_ptr];
    // A beat taken straight through while empty never touches storage.
    assign w_store   = w_push & ~(w_empty & m_r_ready);
    assign w_deq     = m_r_valid & m_r_ready & ~w_empty;
`else
    assign m_r_valid = (r_count != '0);
    assign m_r_data  = r_mem_data[r_rd_ptr];
    assign m_r_id    = r_mem_id[r_rd_ptr];
    assign m_r_last  = r_mem_last[r_rd_ptr];
    assign w_store   = w_push;
    assign w_deq     = m_r_valid & m_r_ready;
`endif

    assign w_pop    = m_r_valid & m_r_ready;
    assign count_o  = r_count;
    assign bursts_o = r_bursts;
    assign err_o    = r_err;

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem_data[r_wr_ptr] <= s_r_data;
            r_mem_id[r_wr_ptr]   <= s_r_id;
            r_mem_last[r_wr_ptr] <= s_r_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_bursts <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_store, w_deq})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            if (w_pop && m_r_last) begin
                r_bursts <= r_bursts + 16'd1;
            end
        end
    end

    // Burst tracking follows accepted slave-side beats, not delivered ones.
    always_comb begin
        w_state_next  = r_state;
        w_capture     = 1'b0;
        w_id_mismatch = 1'b0;
        if (w_push) begin
            case (r_state)
                ST_IDLE: begin
                    w_capture = 1'b1;
                    if (!s_r_last) begin
                        w_state_next = ST_BURST;
                    end
                end
                ST_BURST: begin
                    w_id_mismatch = (s_r_id != r_burst_id);
                    if (s_r_last) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_burst_id <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_burst_id <= s_r_id;
            end
            if (w_id_mismatch) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/dbb_r_fifo.md
Name: dbb_r_fifo

Overview:
- Elastic buffer on the AXI read-data (R) channel of the NVDLA data backbone.
- Sits between the AXI-to-TCDM bridge R outputs (slave side) and the NVDLA DBB R inputs (master side).
- Decouples TCDM read-return timing from NVDLA back-pressure.
- Counts completed read bursts and flags mid-burst ID changes.

Parameters:
- DEPTH, 4, number of R beats stored; power of two, >= 2.
- DATA_WIDTH, 64, R data width in bits.
- ID_WIDTH, 8, AXI ID width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- s_r_valid  input  1  beat valid from bridge.
- s_r_ready  output  1  buffer can accept a beat.
- s_r_data  input  DATA_WIDTH  beat data.
- s_r_id  input  ID_WIDTH  beat ID.
- s_r_last  input  1  last beat of burst.
- m_r_valid  output  1  beat valid toward NVDLA.
- m_r_ready  input  1  NVDLA accepts beat.
- m_r_data  output  DATA_WIDTH  head beat data.
- m_r_id  output  ID_WIDTH  head beat ID.
- m_r_last  output  1  head beat last flag.
- count_o  output  $clog2(DEPTH)+1  beats currently stored.
- bursts_o  output  16  completed bursts delivered to NVDLA; wraps at 65535 -> 0.
- err_o  output  1  sticky ID-mismatch flag.

Behaviour:
- Reset (rst=1 at clock edge): wr_ptr=rd_ptr=0, count_o=0, bursts_o=0, err_o=0, in_burst=0. After reset: m_r_valid=0, s_r_ready=1. Reset mid-burst discards all stored beats; no output beat is presented in the cycle after reset.
- Storage: DEPTH-entry array of {data, id, last}. Pointers are $clog2(DEPTH) bits and wrap naturally DEPTH-1 -> 0.
- s_r_ready = (count_o != DEPTH). It depends on state only, never on s_r_valid or m_r_ready.
- push = s_r_valid & s_r_ready. Push writes the entry at wr_ptr, then wr_ptr+1.
- m_r_valid = (count_o != 0). m_r_data/id/last are the entry at rd_ptr; they hold stable while m_r_valid=1 and m_r_ready=0.
- pop = m_r_valid & m_r_ready. Pop advances rd_ptr+1.
- count_o update: push only +1; pop only -1; both or neither unchanged.
- Full (count=DEPTH): s_r_ready=0, so there is no pass-through. A pop makes s_r_ready=1 in the next cycle.
- Empty (count=0): m_r_valid=0. A push makes m_r_valid=1 in the next cycle, so latency is 1 cycle.
- Burst count: bursts_o increments on pop & m_r_last. 16-bit wrap, no saturation.
- ID check state (on the slave side):
  - On push with in_burst=0: capture burst_id=s_r_id; in_burst = ~s_r_last.
  - On push with in_burst=1: if s_r_id != burst_id, set err_o (sticky until rst); if s_r_last, in_burst=0.
  - Single-beat bursts (last on the first beat) never set err_o.
- s_r_valid while s_r_ready=0 has no effect. The bridge holds the beat per AXI rules; the buffer does not check this.

Optional Feature:
- Macro: DBB_R_FIFO_BYPASS_EN.
- Defined: when count_o=0, m_r_valid=s_r_valid and m_r_data/id/last come combinationally from the s_r_* inputs.
  - If m_r_ready=1 in that cycle, the beat passes through, is not stored, and count_o stays 0; bursts_o and the ID check still update.
  - If m_r_ready=0, the beat is stored normally.
  - Latency is 0 cycles when empty.
- Not defined: latency is always 1 cycle, and all m_r_* outputs come from registered storage only.

Test Plan:
- Reset then idle: m_r_valid=0, s_r_ready=1, count_o=0, bursts_o=0, err_o=0.
- Single beat, data=0xDEADBEEF_00000001, id=3, last=1, m_r_ready=1: m_r_valid high 1 cycle after push with matching fields (0 cycles with bypass); bursts_o=1.
- m_r_ready=0, push 4 beats (DEPTH=4): count_o=4, s_r_ready=0, 5th beat held by source. Raise m_r_ready: beats exit in order, s_r_ready=1 one cycle after first pop.
- Simultaneous push/pop at count=2 for 10 cycles: count_o stays 2, order preserved, no loss.
- Burst of 4 beats, ids 5,5,6,5, last on 4th: err_o=1 after 3rd push and stays 1. Following burst with consistent id does not clear it; only rst clears.
- Reset asserted with 3 beats stored and a burst half pushed: next cycle count_o=0, m_r_valid=0, err_o=0. A new burst with a different id does not set err_o.
- bursts_o preloaded by 65535 single-beat bursts, then one more: bursts_o wraps to 0.
